// File: rtl/test_monitor.sv
// test_monitor: watches core stores to the tohost word and latches a
// pass/fail/timeout verdict together with cycle and retired-instruction counts.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   rst      - synchronous active-high reset
//   wr_en    - data-store strobe, one write per asserted cycle
//   wr_addr  - store address
//   wr_data  - store data
//   wr_be    - store byte enables
//   retire   - one-cycle pulse per retired instruction
//   done     - verdict taken (any outcome)
//   pass     - test passed
//   fail     - test failed, test_num holds the failing case
//   timeout  - no verdict within TIMEOUT cycles
//   test_num - failing test number (wr_data[31:1]); 0 unless failed
//   cycles   - cycles counted up to and including the verdict edge
//   instret  - retired instructions counted up to and including the verdict edge
module test_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] TIMEOUT     = 32'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic        retire,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] test_num,
    output logic [31:0] cycles,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {RUN, PASS, FAIL, TOUT} state_t;

    state_t state, state_n;
    logic   qual;

    // Only full-word odd stores to tohost carry a verdict.
    assign qual = wr_en && (wr_addr == TOHOST_ADDR) && (wr_be == 4'hF) && wr_data[0];

    // A qualifying write wins over an expiring timeout on the same edge.
    always_comb begin
        state_n = state;
        if (state == RUN)
            state_n = qual ? ((wr_data == 32'h1) ? PASS : FAIL)
                           : ((cycles == TIMEOUT - 32'd1) ? TOUT : RUN);
    end

    // Verdict flags are registered from the next state so they appear on the
    // same edge that samples the verdict, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            test_num <= '0;
            cycles   <= '0;
            instret  <= '0;
        end else begin
            state   <= state_n;
            done    <= state_n != RUN;
            pass    <= state_n == PASS;
            fail    <= state_n == FAIL;
            timeout <= state_n == TOUT;
            if (state == RUN) begin
                cycles  <= cycles + 32'd1;
                instret <= instret + {31'd0, retire};
                if (state_n == FAIL)
                    test_num <= wr_data[31:1];
            end
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed scoreboard bench for test_monitor (TIMEOUT=20).
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        retire = 1'b0;
    logic        done, pass, fail, timeout;
    logic [30:0] test_num;
    logic [31:0] cycles, instret;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        d, p, f, t;
        logic [30:0] tn;
        logic [31:0] cy, ir;
    } exp_t;

    exp_t sb[$];

    test_monitor #(.TOHOST_ADDR(32'h0000_1000), .TIMEOUT(32'd20)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .retire(retire),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .test_num(test_num), .cycles(cycles), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic d, p, f, t,
                        input logic [30:0] tn, input logic [31:0] cy, ir);
        exp_t e;
        e.tag = tag; e.d = d; e.p = p; e.f = f; e.t = t; e.tn = tn; e.cy = cy; e.ir = ir;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".done"},     {31'd0, done},    {31'd0, e.d});
        cmp({e.tag, ".pass"},     {31'd0, pass},    {31'd0, e.p});
        cmp({e.tag, ".fail"},     {31'd0, fail},    {31'd0, e.f});
        cmp({e.tag, ".timeout"},  {31'd0, timeout}, {31'd0, e.t});
        cmp({e.tag, ".test_num"}, {1'b0, test_num}, {1'b0, e.tn});
        cmp({e.tag, ".cycles"},   cycles,           e.cy);
        cmp({e.tag, ".instret"},  instret,          e.ir);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; retire = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        push(tag, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        check();
        rst = 1'b0;
    endtask

    initial begin
        step(1);

        // Pass after 10 idle edges, then stickiness against a failing write.
        do_reset("rst_pass");
        step(10);
        wr(32'h1000, 32'h1, 4'hF);
        push("pass", 1, 1, 0, 0, 0, 11, 0);
        step(1);
        check();
        wr(32'h1000, 32'h7, 4'hF);
        retire = 1'b1;
        push("pass_sticky", 1, 1, 0, 0, 0, 11, 0);
        step(3);
        check();

        // Fail with 3 retired instructions.
        do_reset("rst_fail");
        for (int i = 0; i < 3; i++) begin
            retire = 1'b1;
            step(1);
            retire = 1'b0;
            step(1);
        end
        wr(32'h1000, 32'h7, 4'hF);
        push("fail", 1, 0, 1, 0, 3, 7, 3);
        step(1);
        check();
        idle();
        push("fail_sticky", 1, 0, 1, 0, 3, 7, 3);
        step(4);
        check();

        // Ignored writes: wrong address, even data, partial enables, no strobe.
        do_reset("rst_ign");
        wr(32'h1004, 32'h1, 4'hF);
        push("ign_addr", 0, 0, 0, 0, 0, 1, 0);
        step(1);
        check();
        wr(32'h1000, 32'h2, 4'hF);
        push("ign_even", 0, 0, 0, 0, 0, 2, 0);
        step(1);
        check();
        wr(32'h1000, 32'h1, 4'h1);
        push("ign_be", 0, 0, 0, 0, 0, 3, 0);
        step(1);
        check();
        wr(32'h1000, 32'h0, 4'hF);
        push("ign_zero", 0, 0, 0, 0, 0, 4, 0);
        step(1);
        check();
        wr(32'h1000, 32'h1, 4'hF);
        wr_en = 1'b0;
        push("ign_noen", 0, 0, 0, 0, 0, 5, 0);
        step(1);
        check();

        // Timeout at edge 20, frozen afterwards.
        do_reset("rst_tout");
        push("tout_pre", 0, 0, 0, 0, 0, 19, 0);
        step(19);
        check();
        push("tout", 1, 0, 0, 1, 0, 20, 0);
        step(1);
        check();
        retire = 1'b1;
        wr(32'h1000, 32'h1, 4'hF);
        push("tout_sticky", 1, 0, 0, 1, 0, 20, 0);
        step(5);
        check();

        // Qualifying write on the timeout edge wins; later writes ignored.
        do_reset("rst_prio");
        step(19);
        wr(32'h1000, 32'h1, 4'hF);
        push("prio", 1, 1, 0, 0, 0, 20, 0);
        step(1);
        check();
        wr(32'h1000, 32'h7, 4'hF);
        push("prio_sticky", 1, 1, 0, 0, 0, 20, 0);
        step(2);
        check();

        // Reset mid-run with a qualifying write and retire present on the reset edge.
        do_reset("rst_mid0");
        retire = 1'b1;
        push("mid_run", 0, 0, 0, 0, 0, 8, 8);
        step(8);
        check();
        rst = 1'b1;
        wr(32'h1000, 32'h7, 4'hF);
        push("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        step(1);
        check();
        rst = 1'b0;
        idle();
        push("mid_restart", 0, 0, 0, 0, 0, 1, 0);
        step(1);
        check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the word address of the tohost location.
REQ-002 SHALL have parameter TIMEOUT, default 5000, the number of cycles allowed before the test is declared hung; legal range 1 to 2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: core data-store strobe, one write per asserted cycle.
REQ-006 SHALL have port wr_addr, input, 32 bits: store address.
REQ-007 SHALL have port wr_data, input, 32 bits: store data.
REQ-008 SHALL have port wr_be, input, 4 bits: store byte enables.
REQ-009 SHALL have port retire, input, 1 bit: one-cycle pulse per retired instruction.
REQ-010 SHALL have port done, output, 1 bit: test finished, by any outcome.
REQ-011 SHALL have port pass, output, 1 bit: test passed.
REQ-012 SHALL have port fail, output, 1 bit: test failed.
REQ-013 SHALL have port timeout, output, 1 bit: no verdict before TIMEOUT.
REQ-014 SHALL have port test_num, output, 31 bits: number of the failing test case.
REQ-015 SHALL have port cycles, output, 32 bits: cycle count to verdict.
REQ-016 SHALL have port instret, output, 32 bits: retired-instruction count to verdict.

Function
REQ-017 SHALL implement states RUN, PASS, FAIL and TOUT; all outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 SHALL define a qualifying write as: wr_en=1, wr_addr==TOHOST_ADDR, wr_be==4'hF and wr_data[0]==1.
REQ-019 SHALL ignore any write with a different address, partial byte enables, even data (including 0), or arriving outside RUN.
REQ-020 SHALL, in RUN, increment cycles by 1 on every rising edge, including the edge on which the verdict is taken.
REQ-021 SHALL, in RUN, increment instret on each edge where retire=1, including the verdict edge; cycles and instret SHALL wrap modulo 2^32.
REQ-022 SHALL go RUN->PASS on a qualifying write with wr_data==32'h1.
REQ-023 SHALL go RUN->FAIL on a qualifying write with wr_data!=32'h1, and load test_num=wr_data[31:1] on the same edge.
REQ-024 SHALL go RUN->TOUT when no qualifying write is present and cycles==TIMEOUT-1, so that cycles==TIMEOUT after the transition.
REQ-025 SHALL give a qualifying write priority over the timeout when both occur on the same edge.
REQ-026 SHALL set the verdict outputs on the edge that samples the verdict (1-cycle latency): done=1 plus exactly one of pass/fail/timeout=1.
REQ-027 SHALL make PASS, FAIL and TOUT terminal until rst, with cycles, instret and test_num frozen in those states.
REQ-028 SHALL hold test_num=0 unless in FAIL.

Reset
REQ-029 SHALL, on a rising edge with rst=1, enter RUN and clear done, pass, fail, timeout, test_num, cycles and instret to 0, regardless of state or other inputs (including mid-run or post-verdict).
REQ-030 SHALL neither count nor take a verdict on an edge where rst=1; the first count occurs on the first edge with rst=0.

Verification
REQ-031 SHALL be verified for pass: reset, 10 idle edges, write 32'h1 to 32'h1000 with be=4'hF on edge 11 -> next cycle done=1, pass=1, fail=0, timeout=0, cycles=11.
REQ-032 SHALL be verified for fail: reset, 3 retire pulses, then write 32'h7 to tohost -> fail=1, test_num=3, instret=3, pass=0.
REQ-033 SHALL be verified for ignored writes: write 32'h1 to 32'h1004; 32'h2 to tohost; 32'h1 with be=4'h1 -> done stays 0 and state stays RUN.
REQ-034 SHALL be verified for timeout with TIMEOUT=20 and no writes -> timeout=1 and done=1 after edge 20, cycles=20, and cycles unchanged 5 edges later.
REQ-035 SHALL be verified for priority and stickiness with TIMEOUT=20: qualifying write of 32'h1 on edge 20 -> pass=1, timeout=0; a later write of 32'h7 -> outputs unchanged.
REQ-036 SHALL be verified for reset mid-run: rst=1 for 1 edge at cycles=8 -> all outputs 0 and counting restarts at cycles=1 on the next edge.
